seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Consumes the 2-bit digit-select sequence from the display scan driver and drives the
//  4-digit multiplexed 7-segment display of the timer. Takes four BCD digits and decimal
//  points. Applies frame-atomic updates, anti-ghosting blanking, leading-zero suppression
//  and per-digit blink. Sits between the timer datapath/scan driver and the board pins.
// PARAMETERS
//  BLANK_CYCLES   16  clocks with all anodes off after each select change (legal >= 1)
//  BLINK_DIV_BITS 24  width of free-running blink counter; its MSB is the blink phase
// PORTS
//  clock         in   1   system clock
//  reset_n       in   1   reset
//  select_State  in   2   digit index from scan driver (0 = rightmost digit)
//  digits_in     in   16  BCD digits, [3:0]=digit0 ... [15:12]=digit3
//  dp_in         in   4   decimal points, bit i = digit i (1 = lit)
//  load          in   1   capture strobe for digits_in/dp_in
//  lz_blank      in   1   1 = suppress leading zeros
//  blink_mask    in   4   bit i = 1 -> digit i blinks
//  anode_n       out  4   digit enables, active low
//  seg_n         out  7   segments {g,f,e,d,c,b,a}, active low
//  dp_n          out  1   decimal point, active low
//  Interface: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
//  - Reset (async, reset_n=0): anode_n=4'hF, seg_n=7'h7F, dp_n=1. Shadow/display regs=0.
//    pending=0. FSM=BLANK. blank cnt=0. sel_q=0. blink cnt=0. Mid-scan reset turns the
//    display off immediately.
//  - All outputs are registered. No combinational path from inputs to pins.
//  - Load: load=1 at an edge -> shadow <= digits_in/dp_in, pending <= 1. A repeated load
//    while pending overwrites shadow (last wins).
//  - Frame boundary = select_State changes 3->0 (sel_q==3, select_State==0). At a boundary
//    with pending=1: display <= shadow, pending <= 0. If load is also 1 at that edge:
//    display <= digits_in/dp_in directly, pending <= 0. A digit never changes mid-frame.
//  - FSM states BLANK, DRIVE. sel_q <= select_State every edge. change = (select_State != sel_q).
//    DRIVE: change -> BLANK, cnt <= 0, anode_n <= 4'hF at the same edge.
//    BLANK: change -> restart with cnt <= 0. Else if cnt == BLANK_CYCLES-1 -> DRIVE on sel_q.
//    Else cnt++.
//    Change sampled at edge k -> pins dark from edge k. Selected digit lit from edge
//    k+BLANK_CYCLES.
//  - DRIVE outputs for digit i = sel_q: anode_n = ~(1<<i). seg_n = ~decode(display[i]).
//    dp_n = ~dp[i].
//    Blanked digits (LZ or blink-off) hold anode_n=4'hF for the slot. The slot still elapses.
//  - Decode: 0-9 standard patterns. 10-15 -> dash (g only, seg_n=7'b0111111).
//  - Leading zeros (lz_blank=1): d3 blank if 0. d2 blank if 0 and d3 blank. d1 blank if 0
//    and d2 blank. d0 never blanked. A digit whose dp=1 is never LZ-blanked.
//  - Blink: cnt_b free-runs and wraps. MSB=0 -> digits with blink_mask[i]=1 are dark.
//    blink_mask is sampled live, not frame-atomic.
//  - If select_State skips values (e.g. 0->2), it is treated as an ordinary change. The
//    boundary is only 3->0.
// STRUCTURE
//  - disp_pkg: DIGITS=4, SEG_W=7, SEG_* pattern constants (0-9, SEG_DASH, SEG_OFF),
//    FSM state encoding.
//  - Sub-module bcd_to_seg: combinational 4-bit BCD -> 7-bit active-high segment decode.
//  - Top level: shadow/display regs, FSM + blank counter, LZ logic, blink counter,
//    output regs.
// TESTING (bench: BLANK_CYCLES=4, BLINK_DIV_BITS=4)
//  1. Reset with select_State=2, then release -> pins 4'hF/7'h7F/1.
//     Step select 2->3 -> anode_n=4'b0111 exactly 4 edges after the change.
//  2. load digits_in=16'h1234 while sel=1, then scan 1->2->3->0 -> display holds 0000 until
//     the 3->0 boundary. Then slot0 seg_n=~SEG_4 (7'b1100110 inverted), slot3 shows 1.
//  3. lz_blank=1, digits 16'h0070, dp=0 -> digits 3,2 dark, digit1=7, digit0=0 lit.
//     Then dp_in=4'b0100 -> digit2 shows 0 with dp_n=0.
//  4. digit value 4'hB -> seg_n=7'b0111111. blink_mask=4'b0001 -> digit0 dark for 8 clocks,
//     lit for 8 clocks, repeating.
//  5. Toggle select every 2 clocks (< BLANK_CYCLES) -> anode_n stays 4'hF throughout.
//  6. Load at the same edge as a 3->0 boundary (digits 16'h9999) -> next frame shows 9999
//     and pending=0. Assert reset_n=0 mid-DRIVE -> outputs off without a clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the 4-digit multiplexed 7-segment scanner:
//   DIGITS / SEG_W     display geometry
//   SEG_*              active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   scan_state_t       scanner FSM encoding (BLANK = all anodes off, DRIVE = lit)
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD to 7-segment decode, active-high, {g,f,e,d,c,b,a}.
// Non-BCD codes 10..15 show a dash so a corrupted digit is visible on the board.
//   i_bcd  in   4  BCD digit
//   o_seg  out  7  segment pattern (1 = segment lit)
// -----------------------------------------------------------------------------
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Drives a 4-digit multiplexed 7-segment display from the scan driver's digit
// index. Digit values are captured into a shadow register and promoted to the
// display register only at the 3->0 frame boundary, so a frame never mixes old
// and new digits. After every index change all anodes go dark for BLANK_CYCLES
// clocks (anti-ghosting). Leading-zero suppression and per-digit blink blank a
// digit's slot without shortening it. All pins are registered.
//   clock         in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   select_State  in   2   digit index from scan driver (0 = rightmost)
//   digits_in     in   16  BCD digits, [3:0] = digit0 .. [15:12] = digit3
//   dp_in         in   4   decimal points, bit i = digit i (1 = lit)
//   load          in   1   capture strobe for digits_in/dp_in
//   lz_blank      in   1   1 = suppress leading zeros
//   blink_mask    in   4   bit i = 1 -> digit i blinks
//   anode_n       out  4   digit enables, active low
//   seg_n         out  7   segments {g,f,e,d,c,b,a}, active low
//   dp_n          out  1   decimal point, active low
//   dbg_state     out  1   scanner FSM state (0 = BLANK, 1 = DRIVE)
//   dbg_pending   out  1   shadow holds a load not yet shown
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import disp_pkg::*;
#(
    parameter int BLANK_CYCLES   = 16,
    parameter int BLINK_DIV_BITS = 24
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  select_State,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_blank,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  anode_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        dbg_state,
    output logic        dbg_pending
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [15:0]               r_shadow_dig;
    logic [DIGITS-1:0]         r_shadow_dp;
    logic [15:0]               r_disp_dig;
    logic [DIGITS-1:0]         r_disp_dp;
    logic                      r_pending;
    scan_state_t               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [1:0]                r_sel_q;
    logic [BLINK_DIV_BITS-1:0] r_blink;

    logic                      w_change;
    logic                      w_boundary;
    logic [DIGITS-1:0]         w_lz_dark;
    logic [3:0]                w_cur_dig;
    logic [SEG_W-1:0]          w_seg;
    logic                      w_dark;
    logic [3:0]                w_anode_nxt;
    logic [6:0]                w_seg_n_nxt;
    logic                      w_dp_n_nxt;

    assign w_change   = (select_State != r_sel_q);
    assign w_boundary = (r_sel_q == 2'd3) && (select_State == 2'd0);

    // A digit is a leading zero only if every digit to its left is also a
    // blanked zero; a lit decimal point pins the digit (and those right of it).
    assign w_lz_dark[3] = lz_blank && (r_disp_dig[15:12] == 4'd0) && !r_disp_dp[3];
    assign w_lz_dark[2] = w_lz_dark[3] && (r_disp_dig[11:8] == 4'd0) && !r_disp_dp[2];
    assign w_lz_dark[1] = w_lz_dark[2] && (r_disp_dig[7:4] == 4'd0) && !r_disp_dp[1];
    assign w_lz_dark[0] = 1'b0;

    assign w_cur_dig = r_disp_dig[{r_sel_q, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .i_bcd (w_cur_dig),
        .o_seg (w_seg)
    );

    // Blink phase: low half of the blink period darkens masked digits.
    assign w_dark = w_lz_dark[r_sel_q]
                  | (blink_mask[r_sel_q] & ~r_blink[BLINK_DIV_BITS-1]);

    always_comb begin
        w_anode_nxt = 4'hF;
        w_seg_n_nxt = ~SEG_OFF;
        w_dp_n_nxt  = 1'b1;
        if (!w_dark) begin
            w_anode_nxt = ~(4'b0001 << r_sel_q);
            w_seg_n_nxt = ~w_seg;
            w_dp_n_nxt  = ~r_disp_dp[r_sel_q];
        end
    end

    // Shadow / display registers. A load coinciding with the boundary goes
    // straight to the display so it is not delayed by a whole frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_dig <= digits_in;
                r_shadow_dp  <= dp_in;
            end
            if (w_boundary) begin
                if (load) begin
                    r_disp_dig <= digits_in;
                    r_disp_dp  <= dp_in;
                end else if (r_pending) begin
                    r_disp_dig <= r_shadow_dig;
                    r_disp_dp  <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BLINK_DIV_BITS'(1);
        end
    end

    // Scanner FSM. Pins are only ever turned on from the DRIVE path, and both
    // ways into BLANK (reset, select change) turn them off.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_sel_q <= 2'd0;
            anode_n <= 4'hF;
            seg_n   <= ~SEG_OFF;
            dp_n    <= 1'b1;
        end else begin
            r_sel_q <= select_State;
            case (r_state)
                ST_DRIVE: begin
                    if (w_change) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        anode_n <= 4'hF;
                        seg_n   <= ~SEG_OFF;
                        dp_n    <= 1'b1;
                    end else begin
                        anode_n <= w_anode_nxt;
                        seg_n   <= w_seg_n_nxt;
                        dp_n    <= w_dp_n_nxt;
                    end
                end
                default: begin
                    if (w_change) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DRIVE;
                        anode_n <= w_anode_nxt;
                        seg_n   <= w_seg_n_nxt;
                        dp_n    <= w_dp_n_nxt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign dbg_state   = r_state;
    assign dbg_pending = r_pending;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Bench for seven_seg_scanner with BLANK_CYCLES=4, BLINK_DIV_BITS=4.
// A behavioural model tracks "edges since the last select change", the frame
// contents and the blink phase, and predicts the pins after every clock edge.
// Directed sequences and a table of frames cover the corner cases, followed by
// a randomized scan.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int BC  = 4;
    localparam int BDB = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  select_State = 2'd0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        dbg_state;
    logic        dbg_pending;

    seven_seg_scanner #(
        .BLANK_CYCLES   (BC),
        .BLINK_DIV_BITS (BDB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .select_State (select_State),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .load         (load),
        .lz_blank     (lz_blank),
        .blink_mask   (blink_mask),
        .anode_n      (anode_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .dbg_state    (dbg_state),
        .dbg_pending  (dbg_pending)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- counters / reference tables ----------------
    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16];   // expected seg_n (active low) per digit value
    logic [3:0] anode_tab [4];  // expected anode_n per lit slot

    // ---------------- behavioural model ----------------
    int         m_dig [4];
    logic [3:0] m_dp;
    int         m_sh_dig [4];
    logic [3:0] m_sh_dp;
    bit         m_pending;
    int         m_prev_sel;
    int         m_last_change;
    int         m_edge;
    logic [11:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_dig[j]    = 0;
            m_sh_dig[j] = 0;
        end
        m_dp          = 4'h0;
        m_sh_dp       = 4'h0;
        m_pending     = 0;
        m_prev_sel    = 0;
        m_last_change = 0;
        m_edge        = 0;
        exp_q.delete();
    endtask

    // One clock edge: predict pins from the inputs at the edge, then compare.
    task automatic step();
        int          s;
        bit          lit;
        bit          lz_dark;
        bit          blink_dark;
        bit          boundary;
        logic [11:0] e;
        logic [11:0] got;
        @(posedge clock);
        m_edge++;
        s = int'(select_State);
        if (s != m_prev_sel) m_last_change = m_edge;
        lit = (m_edge - m_last_change) >= BC;
        lz_dark = lz_blank && (s != 0);
        for (int j = s; j < 4; j++)
            if (m_dig[j] != 0 || m_dp[j]) lz_dark = 0;
        blink_dark = blink_mask[s] && (((m_edge - 1) % (1 << BDB)) < (1 << (BDB - 1)));
        if (lz_dark || blink_dark) lit = 0;
        e = {4'hF, 7'h7F, 1'b1};
        if (lit) e = {anode_tab[s], seg_tab[m_dig[s]], ~m_dp[s]};
        exp_q.push_back(e);

        boundary = (m_prev_sel == 3) && (s == 0);
        if (boundary && load) begin
            for (int j = 0; j < 4; j++) m_dig[j] = int'(digits_in[4*j +: 4]);
            m_dp = dp_in;
            m_pending = 0;
        end else if (boundary && m_pending) begin
            for (int j = 0; j < 4; j++) m_dig[j] = m_sh_dig[j];
            m_dp = m_sh_dp;
            m_pending = 0;
        end else if (load) begin
            m_pending = 1;
        end
        if (load) begin
            for (int j = 0; j < 4; j++) m_sh_dig[j] = int'(digits_in[4*j +: 4]);
            m_sh_dp = dp_in;
        end
        m_prev_sel = s;

        #1;
        got = {anode_n, seg_n, dp_n};
        e = exp_q.pop_front();
        check("model_anode", got[11:8], e[11:8]);
        if (e[11:8] != 4'hF) begin
            check("model_seg", got[7:1], e[7:1]);
            check("model_dp", got[0], e[0]);
        end
        check("model_pending", dbg_pending, m_pending);
    endtask

    task automatic check_off(input string name);
        check({name, "_anode"}, anode_n, 4'hF);
        check({name, "_seg"}, seg_n, 7'h7F);
        check({name, "_dp"}, dp_n, 1'b1);
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        select_State = sel;
        load = 1'b0;
        lz_blank = 1'b0;
        blink_mask = 4'h0;
        digits_in = 16'h0;
        dp_in = 4'h0;
        #1;
        check_off("reset_async");
        repeat (3) @(posedge clock);
        #1;
        check_off("reset_held");
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic slot(input logic [1:0] s);
        select_State = s;
        repeat (BC + 1) step();
    endtask

    // ---------------- frame table ----------------
    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] an;   // {slot3, slot2, slot1, slot0}
        logic [27:0] sg;   // {slot3, slot2, slot1, slot0}
        logic [3:0]  dpn;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lit_cnt;
        int hold;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        anode_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        vecs[0] = '{16'h0070, 4'b0000, 1'b1, {4'hF, 4'hF, 4'b1101, 4'b1110},
                    {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0100, 1'b1, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1011};
        vecs[2] = '{16'hAB09, 4'b0000, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0111111, 7'b0111111, 7'b1000000, 7'b0010000}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
        vecs[5] = '{16'h5068, 4'b1001, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0010010, 7'b1000000, 7'b0000010, 7'b0000000}, 4'b0110};
        vecs[6] = '{16'h0300, 4'b0000, 1'b1, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'b0110000, 7'b1000000, 7'b1000000}, 4'b1111};

        model_reset();

        // 1. reset with select=2, then blanking latency on 2->3
        do_reset(2'd2);
        repeat (BC + 1) step();
        check("t1_slot2_lit", anode_n, 4'b1011);
        select_State = 2'd3;
        step();
        check("t1_change_edge_dark", anode_n, 4'hF);
        repeat (BC - 1) begin
            step();
            check("t1_blank_dark", anode_n, 4'hF);
        end
        step();
        check("t1_lit_after_4", anode_n, 4'b0111);

        // 2. load mid-frame shows only after the 3->0 boundary
        select_State = 2'd1;
        digits_in = 16'h1234;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (BC) step();
        check("t2_slot1_old", seg_n, 7'b1000000);
        slot(2'd2);
        check("t2_slot2_old", seg_n, 7'b1000000);
        slot(2'd3);
        check("t2_slot3_old", seg_n, 7'b1000000);
        slot(2'd0);
        check("t2_slot0_anode", anode_n, 4'b1110);
        check("t2_slot0_seg4", seg_n, 7'b0011001);
        slot(2'd1);
        slot(2'd2);
        slot(2'd3);
        check("t2_slot3_seg1", seg_n, 7'b1111001);

        // 3/4. frame table: LZ, dp override, dash decode, dp pins
        foreach (vecs[v]) begin
            select_State = 2'd3;
            digits_in = vecs[v].dig;
            dp_in = vecs[v].dp;
            lz_blank = vecs[v].lz;
            load = 1'b1;
            step();
            load = 1'b0;
            repeat (BC) step();
            for (int s = 0; s < 4; s++) begin
                slot(2'(s));
                check("tab_anode", anode_n, vecs[v].an[4*s +: 4]);
                if (vecs[v].an[4*s +: 4] != 4'hF) begin
                    check("tab_seg", seg_n, vecs[v].sg[7*s +: 7]);
                    check("tab_dp", dp_n, vecs[v].dpn[s]);
                end
            end
        end
        lz_blank = 1'b0;
        dp_in = 4'h0;

        // 4b. blink on digit0: 8 dark / 8 lit
        select_State = 2'd3;
        digits_in = 16'h1238;
        load = 1'b1;
        step();
        load = 1'b0;
        select_State = 2'd0;
        blink_mask = 4'b0001;
        repeat (BC) step();
        lit_cnt = 0;
        repeat (32) begin
            step();
            if (anode_n == 4'b1110) lit_cnt++;
        end
        check("t4_blink_lit_count", 16'(lit_cnt), 16'd16);
        blink_mask = 4'h0;

        // 5. select toggling faster than the blanking window never lights
        for (int i = 0; i < 10; i++) begin
            select_State = (i % 2 == 0) ? 2'd2 : 2'd1;
            repeat (2) begin
                step();
                check("t5_fast_toggle_dark", anode_n, 4'hF);
            end
        end

        // 6. load coinciding with the boundary wins over a pending shadow
        slot(2'd3);
        digits_in = 16'h4444;
        load = 1'b1;
        step();
        check("t6_pending_set", dbg_pending, 1'b1);
        select_State = 2'd0;
        digits_in = 16'h9999;
        step();
        load = 1'b0;
        check("t6_pending_clear", dbg_pending, 1'b0);
        repeat (BC) step();
        for (int s = 0; s < 4; s++) begin
            slot(2'(s));
            check("t6_seg9", seg_n, 7'b0010000);
        end
        check("t6_driving", anode_n, 4'b0111);
        #2;
        reset_n = 1'b0;
        #1;
        check_off("t6_midscan_reset");
        check("t6_state_blank", dbg_state, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();

        // random scan against the model
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) != 0) select_State = select_State + 2'd1;
                else select_State = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 10);
            end
            hold--;
            load = ($urandom_range(0, 9) == 0);
            if (load) begin
                for (int j = 0; j < 4; j++)
                    digits_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 39) == 0) blink_mask = 4'($urandom_range(0, 15));
            step();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
